pipelined_adder_tree: RTL and testbench

//   Pipelined, handshaked reduction of N unsigned WIDTH-bit operands to one sum.

---
 rtl/pipelined_adder_tree_pkg.sv | 20 ++
 rtl/pipelined_adder_tree_if.sv | 29 ++
 rtl/pipelined_adder_tree_stage.sv | 68 ++++++
 rtl/pipelined_adder_tree.sv | 64 ++++++
 tb/tb_pipelined_adder_tree.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_tree_pkg.sv
// Shared types and helpers for the pipelined adder tree.
// Output modes, pipeline depth and per-level operand counts.
package adder_tree_pkg;

  typedef enum logic [1:0] {
    WRAP,
    SAT,
    FULL
  } out_mode_e;

  function automatic int levels(int n);
    return $clog2(n);
  endfunction

  // operands left after k pairwise levels: ceil(n / 2**k)
  function automatic int count_at(int n, int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree_if.sv
// Producer/consumer bundle of the adder tree.
// in_valid/in_ready/in in; out_valid/out_ready/sum/overflow out.
interface pipelined_adder_tree_if
  import adder_tree_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int OUT_W = WIDTH + levels(N)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in [N-1:0];
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] sum;
  logic             overflow;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, sum, overflow
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, sum, overflow
  );

endinterface

// File: rtl/pipelined_adder_tree_stage.sv
// One registered tree level: M operands -> ceil(M/2) sums.
// Ports: clk, rst_n, en, vld_in/out, ovf_in/out, d in, q out.
module adder_stage
  import adder_tree_pkg::*;
#(
  parameter int        IN_W     = 8,
  parameter int        M        = 4,
  parameter int        LIM_W    = 8,
  parameter bit        FINAL    = 1'b0,
  parameter out_mode_e OUT_MODE = WRAP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            vld_in,
  input  logic            ovf_in,
  input  logic [IN_W-1:0] d [M],
  output logic            vld_out,
  output logic            ovf_out,
  output logic [IN_W:0]   q [(M+1)/2]
);

  localparam int K = (M + 1) / 2;
  localparam logic [IN_W:0] LIM =
    {{(IN_W + 1 - LIM_W){1'b0}}, {LIM_W{1'b1}}};

  logic [IN_W:0] s [K];
  logic [IN_W:0] r [K];
  logic [K-1:0]  big;
  logic          ovf_nxt;

  for (genvar g = 0; g < K; g++) begin : pair
    if (2 * g + 1 < M) begin : add
      assign s[g] = {1'b0, d[2*g]} + {1'b0, d[2*g+1]};
    end else begin : pass
      assign s[g] = {1'b0, d[2*g]};
    end

    // partial sums only grow, so any one past the limit
    // means the final total is past it too
    assign big[g] = s[g] > LIM;

    if (FINAL && OUT_MODE == WRAP) begin : wrap
      assign r[g] = s[g] & LIM;
    end else if (FINAL && OUT_MODE == SAT) begin : sat
      assign r[g] = ovf_nxt ? LIM : s[g];
    end else begin : keep
      assign r[g] = s[g];
    end
  end

  assign ovf_nxt = ovf_in | (|big);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out <= 1'b0;
      ovf_out <= 1'b0;
      q       <= '{default: '0};
    end else if (en) begin
      vld_out <= vld_in;
      if (vld_in) begin
        q       <= r;
        ovf_out <= ovf_nxt;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined valid/ready reduction of N operands to one sum.
// Ports: clk, rst_n, bus (slave side of pipelined_adder_tree_if).
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int        WIDTH    = 8,
  parameter int        N        = 4,
  parameter out_mode_e OUT_MODE = WRAP
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_adder_tree_if.slave bus
);

  localparam int LEVELS = levels(N);

  logic            en;
  logic [LEVELS:0] vld;
  logic [LEVELS:0] ovf;

  // whole pipeline freezes while the result is refused
  assign en           = ~(vld[LEVELS] & ~bus.out_ready);
  assign bus.in_ready = en;

  assign vld[0] = bus.in_valid;
  assign ovf[0] = 1'b0;

  for (genvar k = 1; k <= LEVELS; k++) begin : lvl
    localparam int M = count_at(N, k - 1);
    localparam int K = count_at(N, k);

    logic [WIDTH+k-2:0] d [M];
    logic [WIDTH+k-1:0] q [K];

    if (k == 1) begin : head
      assign d = bus.in;
    end else begin : link
      assign d = lvl[k-1].q;
    end

    adder_stage #(
      .IN_W    (WIDTH + k - 1),
      .M       (M),
      .LIM_W   (WIDTH),
      .FINAL   (k == LEVELS),
      .OUT_MODE(OUT_MODE)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .vld_in (vld[k-1]),
      .ovf_in (ovf[k-1]),
      .d      (d),
      .vld_out(vld[k]),
      .ovf_out(ovf[k]),
      .q      (q)
    );
  end

  assign bus.out_valid = vld[LEVELS];
  assign bus.overflow  = ovf[LEVELS];
  assign bus.sum       = lvl[LEVELS].q[0];

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench for pipelined_adder_tree.
// Six configurations checked against a queue-based sum model.
module tb_pipelined_adder_tree;
  import adder_tree_pkg::*;

  typedef struct {
    longint s;
    bit     o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_valid, a_oready;
  logic [7:0] a_in [3:0];
  logic        b_valid, b_oready;
  logic [15:0] b_in [7:0];
  logic       c_valid, c_oready;
  logic [3:0] c_in [2:0];

  pipelined_adder_tree_if #(.WIDTH(8), .N(4)) ia0 ();
  pipelined_adder_tree_if #(.WIDTH(8), .N(4)) ia1 ();
  pipelined_adder_tree_if #(.WIDTH(8), .N(4)) ia2 ();
  pipelined_adder_tree_if #(.WIDTH(16), .N(8)) ib ();
  pipelined_adder_tree_if #(.WIDTH(4), .N(3)) ic0 ();
  pipelined_adder_tree_if #(.WIDTH(4), .N(3)) ic1 ();

  assign ia0.in_valid = a_valid;
  assign ia0.in = a_in;
  assign ia0.out_ready = a_oready;
  assign ia1.in_valid = a_valid;
  assign ia1.in = a_in;
  assign ia1.out_ready = a_oready;
  assign ia2.in_valid = a_valid;
  assign ia2.in = a_in;
  assign ia2.out_ready = a_oready;
  assign ib.in_valid = b_valid;
  assign ib.in = b_in;
  assign ib.out_ready = b_oready;
  assign ic0.in_valid = c_valid;
  assign ic0.in = c_in;
  assign ic0.out_ready = c_oready;
  assign ic1.in_valid = c_valid;
  assign ic1.in = c_in;
  assign ic1.out_ready = c_oready;

  pipelined_adder_tree #(.WIDTH(8), .N(4), .OUT_MODE(WRAP))
    d_a0 (.clk(clk), .rst_n(rst_n), .bus(ia0));
  pipelined_adder_tree #(.WIDTH(8), .N(4), .OUT_MODE(SAT))
    d_a1 (.clk(clk), .rst_n(rst_n), .bus(ia1));
  pipelined_adder_tree #(.WIDTH(8), .N(4), .OUT_MODE(FULL))
    d_a2 (.clk(clk), .rst_n(rst_n), .bus(ia2));
  pipelined_adder_tree #(.WIDTH(16), .N(8), .OUT_MODE(WRAP))
    d_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  pipelined_adder_tree #(.WIDTH(4), .N(3), .OUT_MODE(FULL))
    d_c0 (.clk(clk), .rst_n(rst_n), .bus(ic0));
  pipelined_adder_tree #(.WIDTH(4), .N(3), .OUT_MODE(WRAP))
    d_c1 (.clk(clk), .rst_n(rst_n), .bus(ic1));

  exp_t qa0[$], qa1[$], qa2[$], qb[$], qc0[$], qc1[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(out_mode_e m, int w, longint exact);
    longint lim;
    exp_t e;
    lim = (longint'(1) << w) - 1;
    e.o = exact > lim;
    case (m)
      WRAP:    e.s = exact % (lim + 1);
      SAT:     e.s = e.o ? lim : exact;
      default: e.s = exact;
    endcase
    return e;
  endfunction

  task automatic take(input string tag, input logic [63:0] s,
                      input logic o, inout exp_t q[$]);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_stale"}, 64'(1), 64'(0));
    end else begin
      e = q.pop_front();
      chk({tag, "_sum"}, s, 64'(e.s));
      chk({tag, "_ovf"}, 64'(o), 64'(e.o));
    end
  endtask

  // settle inputs, account the transfers of the coming edge,
  // then advance one clock
  task automatic step();
    longint x;
    #1;
    if (rst_n) begin
      if (ia0.out_valid && a_oready) take("a0", ia0.sum, ia0.overflow, qa0);
      if (ia1.out_valid && a_oready) take("a1", ia1.sum, ia1.overflow, qa1);
      if (ia2.out_valid && a_oready) take("a2", ia2.sum, ia2.overflow, qa2);
      if (ib.out_valid && b_oready) take("b", ib.sum, ib.overflow, qb);
      if (ic0.out_valid && c_oready) take("c0", ic0.sum, ic0.overflow, qc0);
      if (ic1.out_valid && c_oready) take("c1", ic1.sum, ic1.overflow, qc1);
      x = 0;
      for (int i = 0; i < 4; i++) x += a_in[i];
      if (a_valid && ia0.in_ready) qa0.push_back(mk(WRAP, 8, x));
      if (a_valid && ia1.in_ready) qa1.push_back(mk(SAT, 8, x));
      if (a_valid && ia2.in_ready) qa2.push_back(mk(FULL, 8, x));
      x = 0;
      for (int i = 0; i < 8; i++) x += b_in[i];
      if (b_valid && ib.in_ready) qb.push_back(mk(WRAP, 16, x));
      x = 0;
      for (int i = 0; i < 3; i++) x += c_in[i];
      if (c_valid && ic0.in_ready) qc0.push_back(mk(FULL, 4, x));
      if (c_valid && ic1.in_ready) qc1.push_back(mk(WRAP, 4, x));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_a();
    for (int i = 0; i < 4; i++) a_in[i] = 8'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 0; b_valid = 0; c_valid = 0;
    a_oready = 1; b_oready = 1; c_oready = 1;
    for (int i = 0; i < 4; i++) a_in[i] = '0;
    for (int i = 0; i < 8; i++) b_in[i] = '0;
    for (int i = 0; i < 3; i++) c_in[i] = '0;
    #12;
    chk("rst_vld", ia0.out_valid, 0);
    chk("rst_sum", ia0.sum, 0);
    chk("rst_ovf", ia0.overflow, 0);
    chk("rst_rdy", ia0.in_ready, 1);
    chk("rst_b_vld", ib.out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic sum, two-cycle latency
    a_in[0] = 10; a_in[1] = 20; a_in[2] = 30; a_in[3] = 40;
    a_valid = 1;
    step();
    a_valid = 0;
    chk("t1_lat1", ia0.out_valid, 0);
    step();
    chk("t1_lat2", ia0.out_valid, 1);
    chk("t1_sum", ia0.sum, 100);
    chk("t1_ovf", ia0.overflow, 0);
    step();

    // overflow in each mode
    a_in[0] = 200; a_in[1] = 150; a_in[2] = 100; a_in[3] = 50;
    a_valid = 1;
    step();
    a_valid = 0;
    step();
    chk("t2_wrap", ia0.sum, 244);
    chk("t2_sat", ia1.sum, 255);
    chk("t2_full", ia2.sum, 500);
    chk("t2_ovf_w", ia0.overflow, 1);
    chk("t2_ovf_s", ia1.overflow, 1);
    chk("t2_ovf_f", ia2.overflow, 1);
    step();

    // back-to-back stream, one result per cycle
    b_valid = 1;
    for (int v = 0; v < 21; v++) begin
      for (int i = 0; i < 8; i++)
        b_in[i] = (v == 0) ? 16'(1000 + 100 * i) : 16'($urandom);
      if (v == 2) chk("t3_lat", ib.out_valid, 0);
      if (v == 3) chk("t3_first", ib.sum, 10800);
      if (v >= 3) chk("t3_thru", ib.out_valid, 1);
      step();
    end
    b_valid = 0;
    for (int i = 0; i < 10 && qb.size() > 0; i++) step();
    chk("t3_drain", 64'(qb.size()), 0);

    // backpressure
    a_oready = 0;
    a_valid = 1;
    for (int v = 0; v < 3; v++) begin
      rand_a();
      step();
    end
    for (int i = 0; i < 5; i++) begin
      chk("t4_rdy", ia0.in_ready, 0);
      chk("t4_vld", ia0.out_valid, 1);
      chk("t4_hold_w", ia0.sum, 64'(qa0[0].s));
      chk("t4_hold_s", ia1.sum, 64'(qa1[0].s));
      step();
    end
    a_oready = 1;
    step();
    a_valid = 0;
    for (int i = 0; i < 10 && qa0.size() > 0; i++) step();
    chk("t4_drain0", 64'(qa0.size()), 0);
    chk("t4_drain1", 64'(qa1.size()), 0);
    chk("t4_drain2", 64'(qa2.size()), 0);

    // odd operand count
    c_in[0] = 7; c_in[1] = 9; c_in[2] = 1;
    c_valid = 1;
    step();
    c_valid = 0;
    step();
    chk("t5_full", ic0.sum, 17);
    chk("t5_ovf", ic0.overflow, 1);
    chk("t5_wrap", ic1.sum, 1);
    chk("t5_ovf_w", ic1.overflow, 1);
    step();
    c_valid = 1;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 3; i++) c_in[i] = 4'($urandom);
      step();
    end
    c_valid = 0;
    for (int i = 0; i < 10 && qc0.size() > 0; i++) step();
    chk("t5_drain0", 64'(qc0.size()), 0);
    chk("t5_drain1", 64'(qc1.size()), 0);

    // reset with work in flight
    a_valid = 1;
    rand_a();
    step();
    rand_a();
    step();
    a_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("t6_vld", ia0.out_valid, 0);
    chk("t6_sum", ia0.sum, 0);
    chk("t6_ovf", ia0.overflow, 0);
    chk("t6_sum_f", ia2.sum, 0);
    qa0.delete(); qa1.delete(); qa2.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_nostale", ia0.out_valid, 0);
      step();
    end
    for (int i = 0; i < 4; i++) a_in[i] = 1;
    a_valid = 1;
    step();
    a_valid = 0;
    step();
    chk("t6_new_vld", ia0.out_valid, 1);
    chk("t6_new_sum", ia0.sum, 4);
    step();
    chk("t6_drain", 64'(qa0.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
